fb_scanout: RTL and testbench
=============================

# fb_scanout

Receiving end of the pixel plot interface driven by the drawing datapath. Accepts single-pixel writes (x, y, colour, plot) into an internal 160x120x3 framebuffer. Continuously scans that framebuffer out as a 640x480@60 Hz VGA signal, replicating each stored pixel 4x4. It replaces the external adapter at the top level and also gives the animator a frame-boundary pulse.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE, 4, replication factor; framebuffer is H_ACTIVE/SCALE x V_ACTIVE/SCALE

Ports:
- Clock  in  1  50 MHz system clock
- Reset  in  1  reset, asynchronous, active-high
- X  in  8  write column, 0..159
- Y  in  7  write row, 0..119
- C  in  3  write colour {R,G,B}
- Plot  in  1  write strobe, sampled every Clock
- VGA_R, VGA_G, VGA_B  out  10 each  colour bit replicated to all 10 bits
- VGA_HS, VGA_VS  out  1 each  active-low syncs
- VGA_BLANK  out  1  active-low blank (0 outside visible area)
- VGA_SYNC  out  1  constant 0
- VGA_CLK  out  1  25 MHz pixel clock, equal to the pixel-phase register
- Frame_start  out  1  one-Clock pulse at the first Clock of line V_ACTIVE (start of vblank)

## Operation
- Write port: on a Clock edge with Plot=1, X<160 and Y<120, mem[Y*160+X] <= C. If X or Y is out of range, nothing is written. One write per Clock; there is no backpressure.
- Address = Y*160+X, 15 bits, computed as (Y<<7)+(Y<<5)+X.
- Memory: 19200 x 3, simple dual-port, initialised to 0. Reset does not clear it.
- Read-during-write to the same address returns the old data.
- Pixel phase: 1-bit register that toggles every Clock. Pixel tick = the Clock on which the phase is 1.
- Counters: h 0..799 and v 0..524, 10 bits each, advanced on pixel ticks. h wraps 799->0 and increments v; v wraps 524->0.
- Visible region: h<640 and v<480.
- Read address = (v>>2)*160 + (h>>2), generated only when visible.
- Sync regions: HS is low for h in 656..751; VS is low for v in 490..491.
- Pipeline:
  - Stage 1 registers the read address together with the raw visible/HS/VS flags.
  - Stage 2 is the memory read.
  - Outputs are registered.
  - Sync and blank flags are delayed through matching stages so they stay aligned with colour.
- Colour output is forced to 0 whenever blank is active.

## Timing
- Reset values:
  - phase=0, h=0, v=0, all pipeline stages cleared
  - VGA_HS=1, VGA_VS=1, VGA_BLANK=0
  - VGA_R/G/B=0, Frame_start=0, VGA_CLK=0
- Latency from counter value to output pins: 2 pixel ticks (4 Clock). All outputs shift by this same amount.
- Line = 800 ticks = 1600 Clock. Frame = 420000 ticks = 840000 Clock.
- Frame_start is high for exactly one Clock per frame, on the pixel tick where the counter v becomes 480 (before the pipeline delay).
- A write at Clock n is visible to any scan read issued at Clock n+1 or later.
- Reset asserted mid-frame returns all outputs to reset values asynchronously. Scan restarts at h=0, v=0 after release; memory contents are kept.

## Structure
- Shared package `vga_pkg` holds:
  - the timing constants
  - FB_WIDTH=160, FB_HEIGHT=120, FB_DEPTH=19200
  - the colour width of 3
- The drawing datapath and the animator import the same constants. This replaces the local width/height defines.
- Sub-module `fb_ram`: dual-port 3-bit RAM with a registered read, inferable as block RAM.
- Counters, pipeline and write decode live in `fb_scanout`.

## Test plan
- Reset check: assert Reset, release, hold 10 Clock -> HS=1, VS=1, BLANK=0 and colour 0 until the first visible pixel reaches the pins.
- Single-pixel write: write (0,0) colour 3'b111 -> at frame output lines 0..3, pixels 0..3 drive R/G/B=1023; pixel 4 drives 0.
- Out-of-range writes are ignored: write (160,5) colour 7 and (10,120) colour 7 -> whole frame stays 0 and (0,5) still reads 0.
- Sync timing:
  - HS low for exactly 192 Clock per line, starting 1312+4 Clock after the line start.
  - VS low for exactly 3200 Clock.
  - Frame period is 840000 Clock.
  - Frame_start period is 840000 Clock with a width of 1.
- Full-frame write then read-during-write:
  - Fill the framebuffer with colour = (x+y)%8 and compare all 640x480 output pixels.
  - Write the address currently being scanned -> the old colour appears that frame and the new colour the next frame.
- Reset mid-frame: assert Reset at v=200 with the framebuffer filled -> outputs return to reset values immediately. After release the first Frame_start comes 480 lines later and the pixel data is intact.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants.
// Imported by the scanout, drawing datapath and animator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_SCALE    = 4;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int COLOR_W   = 3;
  localparam int CNT_W     = 10;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel plot bus from the drawing datapath.
// One write per Clock, no backpressure.
interface fb_scanout_if;
  import vga_pkg::*;

  logic [7:0]         X;
  logic [6:0]         Y;
  logic [COLOR_W-1:0] C;
  logic               Plot;

  modport master (output X, Y, C, Plot);
  modport slave  (input  X, Y, C, Plot);

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM, registered read.
// Read-during-write to one address returns the old data.
module fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = $clog2(FB_DEPTH),
  parameter int W     = COLOR_W
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer write port plus VGA scanout with SCALE x SCALE
// pixel replication and a start-of-vblank pulse.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SCALE    = VGA_SCALE
) (
  input  logic         Clock,
  input  logic         Reset,
  fb_scanout_if.slave  wr,
  output logic [9:0]   VGA_R,
  output logic [9:0]   VGA_G,
  output logic [9:0]   VGA_B,
  output logic         VGA_HS,
  output logic         VGA_VS,
  output logic         VGA_BLANK,
  output logic         VGA_SYNC,
  output logic         VGA_CLK,
  output logic         Frame_start
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE / SCALE;
  localparam int FB_H    = V_ACTIVE / SCALE;
  localparam int DEPTH   = FB_W * FB_H;
  localparam int AW      = $clog2(DEPTH);

  localparam cnt_t HA     = cnt_t'(H_ACTIVE);
  localparam cnt_t VA     = cnt_t'(V_ACTIVE);
  localparam cnt_t HS0    = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS0    = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_PRE  = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t SC     = cnt_t'(SCALE);

  localparam logic [7:0] FB_W8 = 8'(FB_W);
  localparam logic [6:0] FB_H7 = 7'(FB_H);

  logic               phase;
  cnt_t               h, v;
  logic               vis, hs_on, vs_on;
  logic               wr_en;
  logic [AW-1:0]      rd_addr, wr_addr, s1_addr;
  logic               s1_vis, s1_hs, s1_vs;
  logic [COLOR_W-1:0] pix;

  always_comb begin
    vis     = (h < HA) && (v < VA);
    hs_on   = (h >= HS0) && (h < HS1);
    vs_on   = (v >= VS0) && (v < VS1);
    rd_addr = '0;
    if (vis)
      rd_addr = AW'(int'(v / SC) * FB_W + int'(h / SC));
    wr_en   = wr.Plot && (wr.X < FB_W8) && (wr.Y < FB_H7);
    wr_addr = AW'(int'(wr.Y) * FB_W + int'(wr.X));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  fb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (COLOR_W)
  ) u_ram (
    .Clock (Clock),
    .we    (wr_en),
    .wa    (wr_addr),
    .wd    (wr.C),
    .ra    (s1_addr),
    .rd    (pix)
  );

  // RAM reads s1_addr on the off-phase Clock, so the
  // output stage on the next tick sees matching data.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_addr     <= '0;
      s1_vis      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK   <= 1'b0;
      Frame_start <= 1'b0;
    end else begin
      Frame_start <= phase && (h == H_LAST) && (v == V_PRE);
      if (phase) begin
        s1_addr   <= rd_addr;
        s1_vis    <= vis;
        s1_hs     <= hs_on;
        s1_vs     <= vs_on;
        VGA_BLANK <= s1_vis;
        VGA_HS    <= ~s1_hs;
        VGA_VS    <= ~s1_vs;
        VGA_R     <= {10{s1_vis & pix[2]}};
        VGA_G     <= {10{s1_vis & pix[1]}};
        VGA_B     <= {10{s1_vis & pix[0]}};
      end
    end
  end

  assign VGA_SYNC = 1'b0;
  assign VGA_CLK  = phase;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on shrunk timing, against a
// time-indexed model of the scan position and framebuffer.
module tb_fb_scanout;

  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 16;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int SC  = 4;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = HA / SC;
  localparam int FBH = VA / SC;
  localparam int CELLS = FBW * FBH;
  localparam int LIM = 6 * FRAME;
  localparam logic [35:0] RST_PINS =
    {30'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic       Clock;
  logic       Reset;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK;
  logic       VGA_SYNC, VGA_CLK, Frame_start;

  fb_scanout_if pif();

  fb_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SCALE    (SC)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .wr          (pif),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK   (VGA_BLANK),
    .VGA_SYNC    (VGA_SYNC),
    .VGA_CLK     (VGA_CLK),
    .Frame_start (Frame_start)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;
  int k = 0;
  int t = 0;
  bit mon_on = 0;

  logic [2:0] mc [CELLS];
  logic [2:0] mp [CELLS];
  int         mw [CELLS];

  // k: edges since reset release, t: absolute edges
  always @(posedge Clock or posedge Reset)
    if (Reset) k <= 0;
    else k <= k + 1;

  always @(posedge Clock) t <= t + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [35:0] pins();
    return {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
            VGA_BLANK, VGA_SYNC, VGA_CLK, Frame_start};
  endfunction

  function automatic logic [29:0] rep(input logic [2:0] c);
    return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  // Pins after edge kk: the pixel shown at tick j is the
  // scan position of tick j-2, read from memory at edge 2j-1.
  function automatic logic [35:0] expect_pins(int kk, int tt);
    int j, p, h, v, a, rabs;
    logic vis, hs, vs, fs;
    logic [2:0] c;
    j = kk / 2;
    vis = 0; hs = 0; vs = 0; c = '0;
    fs = (kk > 0) && (kk % 2 == 0) && (j % FRAME == VA * HT);
    if (j >= 2) begin
      p   = (j - 2) % FRAME;
      h   = p % HT;
      v   = p / HT;
      vis = (h < HA) && (v < VA);
      hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
      vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
      if (vis) begin
        a    = (v / SC) * FBW + h / SC;
        rabs = tt - kk + 2 * j - 1;
        c    = (rabs > mw[a]) ? mc[a] : mp[a];
      end
    end
    return {rep(c), ~hs, ~vs, vis, 1'b0, (kk % 2) == 1, fs};
  endfunction

  function automatic void model_wr(int a, logic [2:0] c, int w);
    mp[a] = mc[a];
    mc[a] = c;
    mw[a] = w;
  endfunction

  always @(negedge Clock)
    if (mon_on) check("pins", pins(), expect_pins(k, t));

  // Called at a negedge; the write lands on the next edge.
  task automatic plot(input int x, input int y, input logic [2:0] c);
    pif.X = 8'(x);
    pif.Y = 7'(y);
    pif.C = c;
    pif.Plot = 1'b1;
    if (x < FBW && y < FBH) model_wr(y * FBW + x, c, t + 1);
    @(negedge Clock);
    pif.Plot = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic frames(input int nf);
    repeat (2 * FRAME * nf) @(negedge Clock);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Frame_start && n < LIM);
  endtask

  int n, nh, nv, nf, a, jn, p, h, v;
  logic [2:0] oldc, newc;

  initial begin
    for (int i = 0; i < CELLS; i++) begin
      mc[i] = '0; mp[i] = '0; mw[i] = -1;
    end
    Reset = 1'b1;
    pif.X = '0; pif.Y = '0; pif.C = '0; pif.Plot = 1'b0;
    repeat (10) @(negedge Clock);
    check("rst_pins", pins(), RST_PINS);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("post_rst", pins(), expect_pins(k, t));
    end

    for (int i = 0; i < CELLS; i++) plot(i % FBW, i / FBW, 3'd0);
    mon_on = 1;
    frames(1);

    plot(0, 0, 3'b111);
    frames(1);

    plot(160, 5, 3'd7);
    plot(FBW, 1, 3'd7);
    plot(2, FBH, 3'd7);
    plot(10, 120, 3'd7);
    frames(1);
    check("oor_cell", {29'b0, mc[FBW * 2]}, 64'd0);

    nh = 0; nv = 0; nf = 0;
    repeat (2 * FRAME) begin
      @(negedge Clock);
      nh += int'(!VGA_HS);
      nv += int'(!VGA_VS);
      nf += int'(Frame_start);
    end
    check("hs_low", nh, VT * 2 * HSW);
    check("vs_low", nv, 2 * VSW * HT);
    check("fs_width", nf, 1);
    wait_fs(n);
    wait_fs(n);
    check("fs_period", n, 2 * FRAME);

    for (int y = 0; y < FBH; y++)
      for (int x = 0; x < FBW; x++)
        plot(x, y, 3'((x + y) % 8));
    frames(1);

    // write the cell the scan reads on the very next edge
    n = 0;
    do begin
      @(negedge Clock);
      n++;
      jn = k / 2 + 1;
      p  = (jn - 2) % FRAME;
      h  = p % HT;
      v  = p / HT;
    end while (!((k % 2 == 0) && jn >= 2 && h < HA && v < VA)
               && n < LIM);
    check("rdw_wait", n >= LIM, 0);
    a    = (v / SC) * FBW + h / SC;
    oldc = mc[a];
    newc = ~oldc;
    pif.X = 8'(h / SC);
    pif.Y = 7'(v / SC);
    pif.C = newc;
    pif.Plot = 1'b1;
    model_wr(a, newc, t + 1);
    @(negedge Clock);
    pif.Plot = 1'b0;
    @(negedge Clock);
    check("rdw_old", {VGA_R, VGA_G, VGA_B}, rep(oldc));
    repeat (2 * FRAME) @(negedge Clock);
    check("rdw_new", {VGA_R, VGA_G, VGA_B}, rep(newc));

    repeat (200)
      plot($urandom_range(0, FBW), $urandom_range(0, FBH),
           3'($urandom));
    frames(1);

    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (((k / 2) % FRAME) / HT != VA / 2 && n < LIM);
    #5 Reset = 1'b1;
    #1 check("rst_async", pins(), RST_PINS);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    wait_fs(n);
    check("first_fs", n, 2 * VA * HT);
    frames(2);

    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
